// File: rtl/lfsr_burst_ctrl.sv
// Burst controller sitting downstream of a Galois LFSR: loads the seed,
// streams len pseudo-random words on a valid/ready port and keeps a running
// XOR checksum and beat count of the accepted words.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_start; outputs hold last burst's count/checksum
// LOAD   | one-cycle load strobe pushes the latched seed into the LFSR
// PRIME  | LFSR now holds the seed; capture it as first beat, advance LFSR
// STREAM | presenting beats; each transfer captures the next LFSR state
// DONE   | one-cycle done pulse, busy already low
module lfsr_burst_ctrl #(
    parameter int N     = 8,
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [N-1:0]     i_seed,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_lfsr_load,
    output logic [N-1:0]     o_lfsr_seed,
    output logic             o_lfsr_count_en,
    input  logic [N-1:0]     i_lfsr,
    output logic [N-1:0]     o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_count,
    output logic [N-1:0]     o_xsum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_STREAM,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic             xfer;
    logic             last_beat;

    assign xfer      = o_valid && i_ready;
    // len_q is never 0 while streaming, so len_q-1 cannot underflow here
    assign last_beat = (o_count == (len_q - LEN_W'(1)));

    // Next-state and strobe decode; LFSR advances only in PRIME or on a non-final transfer
    always_comb begin
        state_d         = state_q;
        o_lfsr_load     = 1'b0;
        o_lfsr_count_en = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = (i_len != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: begin
                o_busy      = 1'b1;
                o_lfsr_load = 1'b1;
                state_d     = S_PRIME;
            end
            S_PRIME: begin
                o_busy          = 1'b1;
                o_lfsr_count_en = 1'b1;
                state_d         = S_STREAM;
            end
            S_STREAM: begin
                o_busy = 1'b1;
                if (xfer) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        o_lfsr_count_en = 1'b1;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register plus datapath: seed/len latch, stream register, count and checksum
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            o_lfsr_seed <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_count     <= '0;
            o_xsum      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        o_count <= '0;
                        o_xsum  <= '0;
                        if (i_len != '0) begin
                            o_lfsr_seed <= i_seed;
                            len_q       <= i_len;
                        end
                    end
                end
                S_PRIME: begin
                    o_data  <= i_lfsr;
                    o_valid <= 1'b1;
                end
                S_STREAM: begin
                    if (xfer) begin
                        o_xsum  <= o_xsum ^ o_data;
                        o_count <= o_count + LEN_W'(1);
                        if (last_beat) begin
                            o_valid <= 1'b0;
                        end else begin
                            o_data <= i_lfsr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Randomized bench for lfsr_burst_ctrl with an attached 8-bit Galois LFSR
// (poly 0x9b); expected bursts come from a list-based reference model.
module tb_lfsr_burst_ctrl;

    localparam int N     = 8;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     seed;
    logic [LEN_W-1:0] len;
    logic             lfsr_load;
    logic [N-1:0]     lfsr_seed;
    logic             lfsr_count_en;
    logic [N-1:0]     lfsr;
    logic [N-1:0]     data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] count;
    logic [N-1:0]     xsum;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lfsr_burst_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_seed          (seed),
        .i_len           (len),
        .o_lfsr_load     (lfsr_load),
        .o_lfsr_seed     (lfsr_seed),
        .o_lfsr_count_en (lfsr_count_en),
        .i_lfsr          (lfsr),
        .o_data          (data),
        .o_valid         (valid),
        .i_ready         (ready),
        .o_busy          (busy),
        .o_done          (done),
        .o_count         (count),
        .o_xsum          (xsum)
    );

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return v[7] ? ({v[6:0], 1'b0} ^ 8'h9b) : {v[6:0], 1'b0};
    endfunction

    // Attached LFSR: load wins over advance
    always @(posedge clk) begin
        if (lfsr_load)          lfsr <= lfsr_seed;
        else if (lfsr_count_en) lfsr <= lfsr_next(lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_data"},  32'(data),  0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"},  32'(busy),  0);
        chk({tag, "_done"},  32'(done),  0);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_xsum"},  32'(xsum),  0);
        chk({tag, "_seed"},  32'(lfsr_seed), 0);
        chk({tag, "_load"},  32'(lfsr_load), 0);
        chk({tag, "_cnten"}, 32'(lfsr_count_en), 0);
    endtask

    // mode: 0 ready always high, 1 fixed toggle pattern once valid, 2 random
    task automatic run_burst(input logic [7:0] s, input logic [15:0] l, input int mode, input bit poke);
        logic [7:0] exp_q[$];
        logic [7:0] v;
        logic [7:0] exp_x;
        logic       pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int         p = 0;
        int         nb = 0;
        int         loads = 0;
        int         advs = 0;
        int         first_k = -1;
        int         last_k = -1;
        int         done_k = -1;
        int         budget;
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic [7:0] prev_data = '0;

        v = s;
        exp_x = '0;
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back(v);
            exp_x ^= v;
            v = lfsr_next(v);
        end
        budget = 30 * int'(l) + 40;

        @(posedge clk); #1;
        start = 1'b1; seed = s; len = l; ready = 1'b1;
        #1;
        chk("start_busy", 32'(busy), 0);

        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            start = poke && (k == 5);
            if (poke) begin seed = 8'h55; len = 16'd3; end
            case (mode)
                0: ready = 1'b1;
                1: begin
                    if (valid) begin
                        ready = (p < 7) ? pat[p] : 1'b1;
                        p++;
                    end else ready = 1'b1;
                end
                default: ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (lfsr_load) loads++;
            if (lfsr_count_en) advs++;
            if (lfsr_load && lfsr_count_en) chk("load_and_adv", 1, 0);
            if (prev_valid && !prev_ready) begin
                chk("stall_valid", 32'(valid), 1);
                chk("stall_data", 32'(data), 32'(prev_data));
            end
            if (valid && first_k < 0) first_k = k;
            if (valid && ready) begin
                if (nb < exp_q.size()) chk("beat_data", 32'(data), 32'(exp_q[nb]));
                else chk("extra_beat", 32'(nb), 32'(exp_q.size()));
                nb++;
                last_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
            chk("busy_in_burst", 32'(busy), 1);
            prev_valid = valid; prev_ready = ready; prev_data = data;
        end
        start = 1'b0;

        if (done_k < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_busy", 32'(busy), 0);
            chk("done_valid", 32'(valid), 0);
            chk("done_count", 32'(count), 32'(l));
            chk("done_xsum", 32'(xsum), 32'(exp_x));
            chk("done_k", 32'(done_k), (l == 0) ? 32'd1 : 32'(last_k + 1));
        end
        chk("beats", 32'(nb), 32'(l));
        chk("loads", 32'(loads), (l == 0) ? 32'd0 : 32'd1);
        chk("advances", 32'(advs), 32'(l));
        chk("first_valid_k", 32'(first_k), (l == 0) ? 32'hffffffff : 32'd3);

        @(posedge clk); #2;
        chk("post_done", 32'(done), 0);
        chk("hold_count", 32'(count), 32'(l));
        chk("hold_xsum", 32'(xsum), 32'(exp_x));
    endtask

    initial begin
        int nx;
        rst = 1'b1; start = 1'b0; seed = '0; len = '0; ready = 1'b0; lfsr = '0;
        repeat (3) @(posedge clk);
        #2;
        chk_idle_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_burst(8'h01, 16'd4,  0, 1'b0);
        run_burst(8'h01, 16'd10, 0, 1'b0);
        run_burst(8'h01, 16'd4,  1, 1'b0);
        run_burst(8'h00, 16'd0,  0, 1'b0);
        run_burst(8'hA5, 16'd1,  0, 1'b0);
        run_burst(8'h01, 16'd6,  0, 1'b1);
        run_burst(8'h00, 16'd5,  2, 1'b0);
        run_burst(8'h3c, 16'd300, 2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            run_burst(8'($urandom), 16'($urandom_range(0, 24)), 2, ($urandom_range(0, 1) == 1));
        end

        // Reset after the second beat abandons the burst
        @(posedge clk); #1;
        start = 1'b1; seed = 8'h01; len = 16'd6; ready = 1'b1;
        nx = 0;
        for (int k = 0; k < 20 && nx < 2; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (valid && ready) nx++;
        end
        chk("pre_rst_beats", 32'(nx), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_idle_zero("midrst");
        run_burst(8'h01, 16'd2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
